// File: rtl/gpu_pkg.sv
// Shared GPU front-end types: topology and assembler FSM encodings, data widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpu_pkg;

    localparam int POS_W  = 128;   // one clip-space position, 4 x 32-bit
    localparam int VARY_W = 256;   // one vertex varying bundle

    typedef enum logic [1:0] {
        TOPO_LIST  = 2'd0,
        TOPO_STRIP = 2'd1,
        TOPO_FAN   = 2'd2,
        TOPO_RSVD  = 2'd3
    } topo_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2,
        ST_DONE    = 2'd3
    } pa_state_e;

    // The reserved encoding behaves exactly like a triangle list.
    function automatic topo_e norm_topo(input logic [1:0] t);
        return (t == TOPO_RSVD) ? TOPO_LIST : topo_e'(t);
    endfunction

endpackage

// File: rtl/prim_degen_detect.sv
// Flags a triangle whose positions contain any bit-identical pair.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module prim_degen_detect #(
    parameter int W = 128
) (
    input  logic [W-1:0] pos0,
    input  logic [W-1:0] pos1,
    input  logic [W-1:0] pos2,
    output logic         degen
);

    assign degen = (pos0 == pos1) || (pos1 == pos2) || (pos0 == pos2);

endmodule

// File: rtl/primitive_assembler.sv
// Assembles list/strip/fan vertex streams into triangles; optional degenerate cull (PRIM_ASM_DEGEN_CULL_EN).
// Latency: tri_valid_o rises the cycle after the vertex that completes a triangle is accepted.
// Backpressure: one triangle in flight; vtx_ready_o drops while a triangle waits for tri_ready_i.
module primitive_assembler
    import gpu_pkg::*;
#(
    parameter int POS_WIDTH  = POS_W,
    parameter int VARY_WIDTH = VARY_W
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic                    start_i,
    input  logic [1:0]              topology_i,
    input  logic [31:0]             vertex_count_i,
    input  logic [POS_WIDTH-1:0]    pos_i,
    input  logic [VARY_WIDTH-1:0]   vary_i,
    input  logic                    vtx_valid_i,
    output logic                    vtx_ready_o,
    output logic [3*POS_WIDTH-1:0]  tri_pos_o,
    output logic [3*VARY_WIDTH-1:0] tri_vary_o,
    output logic                    tri_valid_o,
    input  logic                    tri_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [31:0]             tri_counter_o,
    output logic [31:0]             cull_counter_o
);

    pa_state_e               state_q, state_d;
    topo_e                   topo_q;
    logic [31:0]             count_q;
    logic [31:0]             vtx_cnt_q;      // vertices accepted so far in this draw
    logic [1:0]              list_phase_q;   // position within the current list triple
    logic [POS_WIDTH-1:0]    slot_a_pos, slot_b_pos;
    logic [VARY_WIDTH-1:0]   slot_a_vary, slot_b_vary;
    logic [31:0]             tri_cnt_q;

    logic                    start_go;
    logic                    accept;
    logic                    forms_tri;
    logic                    last_vtx;
    logic                    all_consumed;
    logic                    degen;
    logic                    emit_load;
    logic [POS_WIDTH-1:0]    f_pos0, f_pos1;
    logic [VARY_WIDTH-1:0]   f_vary0, f_vary1;

    assign start_go     = (state_q == ST_IDLE) && start_i && enable_i;
    assign accept       = vtx_valid_i && vtx_ready_o;
    assign last_vtx     = ((vtx_cnt_q + 32'd1) == count_q);
    assign all_consumed = (vtx_cnt_q == count_q);
    assign emit_load    = accept && forms_tri && !degen;

    // Decide whether the incoming vertex closes a triangle and which stored vertices lead it.
    // Slot A/B always hold the two vertices preceding the incoming one in the order the
    // triangle wants them, except odd strip triangles which swap them to keep winding.
    always_comb begin
        forms_tri = 1'b0;
        f_pos0    = slot_a_pos;
        f_pos1    = slot_b_pos;
        f_vary0   = slot_a_vary;
        f_vary1   = slot_b_vary;
        case (topo_q)
            TOPO_STRIP: begin
                forms_tri = |vtx_cnt_q[31:1];
                if (vtx_cnt_q[0]) begin
                    f_pos0  = slot_b_pos;
                    f_pos1  = slot_a_pos;
                    f_vary0 = slot_b_vary;
                    f_vary1 = slot_a_vary;
                end
            end
            TOPO_FAN:   forms_tri = |vtx_cnt_q[31:1];
            default:    forms_tri = (list_phase_q == 2'd2);
        endcase
    end

`ifdef PRIM_ASM_DEGEN_CULL_EN
    logic        cull_hit;
    logic [31:0] cull_cnt_q;

    assign cull_hit = accept && forms_tri && degen;

    prim_degen_detect #(
        .W (POS_WIDTH)
    ) u_degen (
        .pos0  (f_pos0),
        .pos1  (f_pos1),
        .pos2  (pos_i),
        .degen (degen)
    );

    // Count culled triangles for the current draw.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)      cull_cnt_q <= '0;
        else if (start_go) cull_cnt_q <= '0;
        else if (cull_hit) cull_cnt_q <= cull_cnt_q + 32'd1;
    end

    assign cull_counter_o = cull_cnt_q;
`else
    assign degen          = 1'b0;
    assign cull_counter_o = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic; a culled triangle behaves like an instantly drained one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_go) state_d = (vertex_count_i == 32'd0) ? ST_DONE : ST_COLLECT;
            end
            ST_COLLECT: begin
                if (emit_load)     state_d = ST_EMIT;
                else if (accept && last_vtx) state_d = ST_DONE;
            end
            ST_EMIT: begin
                if (tri_ready_i) state_d = all_consumed ? ST_DONE : ST_COLLECT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        vtx_ready_o = (state_q == ST_COLLECT) && enable_i;
        tri_valid_o = (state_q == ST_EMIT);
        busy_o      = (state_q != ST_IDLE);
        done_o      = (state_q == ST_DONE);
    end

    // Draw parameters and vertex history slots.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            topo_q       <= TOPO_LIST;
            count_q      <= '0;
            vtx_cnt_q    <= '0;
            list_phase_q <= '0;
            slot_a_pos   <= '0;
            slot_b_pos   <= '0;
            slot_a_vary  <= '0;
            slot_b_vary  <= '0;
        end else if (start_go) begin
            topo_q       <= norm_topo(topology_i);
            count_q      <= vertex_count_i;
            vtx_cnt_q    <= '0;
            list_phase_q <= '0;
            slot_a_pos   <= '0;
            slot_b_pos   <= '0;
            slot_a_vary  <= '0;
            slot_b_vary  <= '0;
        end else if (accept) begin
            vtx_cnt_q    <= vtx_cnt_q + 32'd1;
            list_phase_q <= (list_phase_q == 2'd2) ? 2'd0 : list_phase_q + 2'd1;
            case (topo_q)
                TOPO_STRIP: begin
                    if (vtx_cnt_q == 32'd0) begin
                        slot_a_pos  <= pos_i;
                        slot_a_vary <= vary_i;
                    end else if (vtx_cnt_q == 32'd1) begin
                        slot_b_pos  <= pos_i;
                        slot_b_vary <= vary_i;
                    end else begin
                        slot_a_pos  <= slot_b_pos;
                        slot_a_vary <= slot_b_vary;
                        slot_b_pos  <= pos_i;
                        slot_b_vary <= vary_i;
                    end
                end
                TOPO_FAN: begin
                    // Slot A keeps the fan centre for the whole draw.
                    if (vtx_cnt_q == 32'd0) begin
                        slot_a_pos  <= pos_i;
                        slot_a_vary <= vary_i;
                    end else begin
                        slot_b_pos  <= pos_i;
                        slot_b_vary <= vary_i;
                    end
                end
                default: begin
                    if (list_phase_q == 2'd0) begin
                        slot_a_pos  <= pos_i;
                        slot_a_vary <= vary_i;
                    end else if (list_phase_q == 2'd1) begin
                        slot_b_pos  <= pos_i;
                        slot_b_vary <= vary_i;
                    end
                end
            endcase
        end
    end

    // Triangle output register, held until the downstream handshake.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tri_pos_o  <= '0;
            tri_vary_o <= '0;
        end else if (emit_load) begin
            tri_pos_o  <= {pos_i, f_pos1, f_pos0};
            tri_vary_o <= {vary_i, f_vary1, f_vary0};
        end
    end

    // Count triangles handed downstream in the current draw.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                              tri_cnt_q <= '0;
        else if (start_go)                         tri_cnt_q <= '0;
        else if (state_q == ST_EMIT && tri_ready_i) tri_cnt_q <= tri_cnt_q + 32'd1;
    end

    assign tri_counter_o = tri_cnt_q;

endmodule
